// File: rtl/axi4_master_write_router_if.sv
// Master-side AW/W channels plus the fanned-out slave-side AW/W channels of one write router.
// The router uses the slave modport; the upstream master and downstream slaves use the master modport.
interface axi4_master_write_router_if #(
  parameter int SLAVE_NUM    = 8,
  parameter int ID_LEN       = 4,
  parameter int EXTRA_ID_LEN = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64
);
  logic [ID_LEN-1:0]              m_awid;
  logic [ADDR_WIDTH-1:0]          m_awaddr;
  logic [7:0]                     m_awlen;
  logic [2:0]                     m_awsize;
  logic [1:0]                     m_awburst;
  logic                           m_awvalid;
  logic                           m_awready;
  logic [DATA_WIDTH-1:0]          m_wdata;
  logic [DATA_WIDTH/8-1:0]        m_wstrb;
  logic                           m_wlast;
  logic                           m_wvalid;
  logic                           m_wready;

  logic [EXTRA_ID_LEN+ID_LEN-1:0] s_awid;
  logic [ADDR_WIDTH-1:0]          s_awaddr;
  logic [7:0]                     s_awlen;
  logic [2:0]                     s_awsize;
  logic [1:0]                     s_awburst;
  logic [SLAVE_NUM-1:0]           s_awvalid;
  logic [SLAVE_NUM-1:0]           s_awready;
  logic [DATA_WIDTH-1:0]          s_wdata;
  logic [DATA_WIDTH/8-1:0]        s_wstrb;
  logic                           s_wlast;
  logic [SLAVE_NUM-1:0]           s_wvalid;
  logic [SLAVE_NUM-1:0]           s_wready;

  modport slave (
    input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wlast, s_wvalid,
    input  s_wready
  );

  modport master (
    output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wlast, s_wvalid,
    output s_wready
  );
endinterface

// File: rtl/axi4_master_write_router.sv
// Per-master write router: decodes AWADDR to a slave, prefixes the master index onto AWID,
// and steers W bursts in AW order through a small ordering FIFO while checking WLAST placement.
module axi4_master_write_router #(
  parameter int MASTER_IDX   = 0,
  parameter int SLAVE_NUM    = 8,
  parameter int SEL_W        = 3,
  parameter int ID_LEN       = 4,
  parameter int EXTRA_ID_LEN = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int BUF_DEPTH    = 2,
  localparam int CNT_W       = $clog2(BUF_DEPTH + 1),
  localparam int PTR_W       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  axi4_master_write_router_if.slave     bus,
  output logic [CNT_W-1:0]              outstanding,
  output logic                          w_len_err
);

  if (SLAVE_NUM != (1 << SEL_W)) begin : g_bad_sel
    $error("SLAVE_NUM must equal 2**SEL_W");
  end
  if (BUF_DEPTH < 1 || ID_LEN < 1 || (DATA_WIDTH % 8) != 0) begin : g_bad_cfg
    $error("invalid BUF_DEPTH, ID_LEN or DATA_WIDTH");
  end

  logic [SEL_W-1:0] selMem_q [BUF_DEPTH];
  logic [7:0]       lenMem_q [BUF_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       beatCnt_q, beatCnt_d;
  logic             lenErr_q, lenErr_d;

  logic [SEL_W-1:0] awSel, hSel;
  logic [7:0]       hLen;
  logic             full, empty, push, pop, wHs;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign awSel = bus.m_awaddr[ADDR_WIDTH-1 -: SEL_W];
  assign full  = (count_q == CNT_W'(BUF_DEPTH));
  assign empty = (count_q == '0);
  assign hSel  = selMem_q[rdPtr_q];
  assign hLen  = lenMem_q[rdPtr_q];

  assign bus.s_awid    = {EXTRA_ID_LEN'(MASTER_IDX), bus.m_awid};
  assign bus.s_awaddr  = bus.m_awaddr;
  assign bus.s_awlen   = bus.m_awlen;
  assign bus.s_awsize  = bus.m_awsize;
  assign bus.s_awburst = bus.m_awburst;
  assign bus.s_wdata   = bus.m_wdata;
  assign bus.s_wstrb   = bus.m_wstrb;
  assign bus.s_wlast   = bus.m_wlast;

  // AW is steered straight from the decode; a full FIFO stalls it even if a pop is pending.
  always_comb begin
    bus.s_awvalid        = '0;
    bus.s_awvalid[awSel] = bus.m_awvalid & ~full;
    bus.m_awready        = bus.s_awready[awSel] & ~full;
  end

  // W only flows once the head FIFO entry names its destination slave.
  always_comb begin
    bus.s_wvalid = '0;
    bus.m_wready = 1'b0;
    if (!empty) begin
      bus.s_wvalid[hSel] = bus.m_wvalid;
      bus.m_wready       = bus.s_wready[hSel];
    end
  end

  assign push = bus.m_awvalid & bus.m_awready;
  assign wHs  = bus.m_wvalid & bus.m_wready;
  assign pop  = wHs & bus.m_wlast;

  always_comb begin
    wrPtr_d   = push ? nextPtr(wrPtr_q) : wrPtr_q;
    rdPtr_d   = pop  ? nextPtr(rdPtr_q) : rdPtr_q;
    count_d   = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    beatCnt_d = beatCnt_q;
    lenErr_d  = 1'b0;
    if (wHs) begin
      // Overrun beats keep counting so a late WLAST is also flagged; saturate at 255.
      if (bus.m_wlast) begin
        beatCnt_d = '0;
        lenErr_d  = (beatCnt_q != hLen);
      end else begin
        if (beatCnt_q != 8'hFF) beatCnt_d = beatCnt_q + 1'b1;
        lenErr_d = (beatCnt_q == hLen);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) begin
      selMem_q[wrPtr_q] <= awSel;
      lenMem_q[wrPtr_q] <= bus.m_awlen;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      beatCnt_q <= '0;
      lenErr_q  <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      beatCnt_q <= beatCnt_d;
      lenErr_q  <= lenErr_d;
    end
  end

  assign outstanding = count_q;
  assign w_len_err   = lenErr_q;

endmodule
